// File: rtl/fan_ctrl_multi.sv
// Multi-channel PWM fan controller: per-channel soft-start duty ramp, tachometer
// pulse counting over a fixed window, sticky stall detection with optional failsafe.
module fan_ctrl_multi #(
    parameter int unsigned NumFans        = 2,
    parameter int unsigned SettingWidth   = 4,
    parameter int unsigned PwmWidth       = 8,
    parameter int unsigned PrescaleDiv    = 16,
    parameter int unsigned RampStep       = 16,
    parameter int unsigned TachWindow     = 1000000,
    parameter int unsigned TachCntWidth   = 16,
    parameter int unsigned StallMinPulses = 2,
    parameter int unsigned FailsafeEn     = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic [NumFans*SettingWidth-1:0]  setting_i,
    input  logic [NumFans-1:0]               tach_i,
    output logic [NumFans-1:0]               fan_pwm_o,
    output logic [NumFans*TachCntWidth-1:0]  tach_count_o,
    output logic                             tach_valid_o,
    output logic [NumFans-1:0]               stall_o
);

    localparam int unsigned PresW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
    localparam int unsigned WinW  = (TachWindow > 1) ? $clog2(TachWindow) : 1;
    localparam int unsigned DutyW = PwmWidth + 1;
    localparam int unsigned RampW = PwmWidth + 2;
    localparam logic [DutyW-1:0]        FullDuty   = DutyW'(2 ** PwmWidth);
    localparam logic [SettingWidth-1:0] SettingMax = SettingWidth'((2 ** SettingWidth) - 1);

    logic [1:0]                              rst_sync_q;
    logic                                    rst_int;
    logic [PresW-1:0]                        presc_q, presc_d;
    logic                                    tick;
    logic [PwmWidth-1:0]                     pwm_cnt_q, pwm_cnt_d;
    logic                                    period_start;
    logic [NumFans-1:0][SettingWidth-1:0]    setting;
    logic [NumFans-1:0][DutyW-1:0]           target, duty_q, duty_d;
    logic [NumFans-1:0][RampW-1:0]           duty_up, duty_dn;
    logic [NumFans-1:0]                      pwm_q, pwm_d;
    logic [NumFans-1:0]                      sync1_q, sync2_q, prev_q, rise;
    logic [WinW-1:0]                         win_q, win_d;
    logic                                    win_end;
    logic [NumFans-1:0][TachCntWidth-1:0]    pulse_q, pulse_d, count_q, count_d;
    logic                                    valid_q;
    logic [NumFans-1:0]                      stall_q, stall_d;

    assign setting      = setting_i;
    assign fan_pwm_o    = pwm_q;
    assign tach_count_o = count_q;
    assign tach_valid_o = valid_q;
    assign stall_o      = stall_q;
    assign rst_int      = rst_sync_q[1];
    assign rise         = sync2_q & ~prev_q;

    // Reset asserts immediately but releases two clocks after rst_i falls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    // PWM timebase
    always_comb begin
        tick         = (presc_q == PresW'(PrescaleDiv - 1));
        presc_d      = tick ? '0 : presc_q + PresW'(1);
        pwm_cnt_d    = tick ? pwm_cnt_q + PwmWidth'(1) : pwm_cnt_q;
        period_start = tick && (pwm_cnt_q == '1);
    end

    // Per-channel target, ramped duty and PWM compare
    always_comb begin
        target  = '0;
        duty_up = '0;
        duty_dn = '0;
        duty_d  = duty_q;
        pwm_d   = '0;
        for (int k = 0; k < NumFans; k++) begin
            if (setting[k] == SettingMax) begin
                target[k] = FullDuty;
            end else begin
                target[k] = DutyW'(setting[k]) << (PwmWidth - SettingWidth);
            end
            if ((FailsafeEn != 0) && stall_q[k]) begin
                target[k] = FullDuty;
            end
            duty_up[k] = RampW'(duty_q[k]) + RampW'(RampStep);
            duty_dn[k] = RampW'(duty_q[k]) - RampW'(target[k]);
            if (!en_i) begin
                duty_d[k] = '0;
            end else if (period_start) begin
                if (target[k] > duty_q[k]) begin
                    duty_d[k] = (duty_up[k] > RampW'(target[k])) ? target[k] : DutyW'(duty_up[k]);
                end else if (target[k] < duty_q[k]) begin
                    duty_d[k] = (duty_dn[k] > RampW'(RampStep))
                              ? DutyW'(RampW'(duty_q[k]) - RampW'(RampStep)) : target[k];
                end
            end
            pwm_d[k] = en_i && (DutyW'(pwm_cnt_q) < duty_q[k]);
        end
    end

    // Tach window, pulse counting and stall evaluation
    always_comb begin
        win_end = (win_q == WinW'(TachWindow - 1));
        win_d   = win_end ? '0 : win_q + WinW'(1);
        pulse_d = pulse_q;
        count_d = count_q;
        stall_d = stall_q;
        for (int k = 0; k < NumFans; k++) begin
            if (win_end) begin
                pulse_d[k] = rise[k] ? TachCntWidth'(1) : '0;
                count_d[k] = pulse_q[k];
                stall_d[k] = (duty_q[k] != '0) && (pulse_q[k] < TachCntWidth'(StallMinPulses));
            end else if (rise[k] && (pulse_q[k] != '1)) begin
                pulse_d[k] = pulse_q[k] + TachCntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            win_q     <= '0;
            pulse_q   <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            stall_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            sync1_q   <= tach_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            win_q     <= win_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            valid_q   <= win_end;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Scoreboard bench for fan_ctrl_multi: per-period PWM high counts and per-window
// tach reports are queued by the stimulus and matched by an independent monitor.
module tb_fan_ctrl_multi;

    localparam int unsigned TW = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en;
    logic [7:0]  setting;
    logic [1:0]  tach;
    logic [1:0]  fan_pwm;
    logic [31:0] tach_count;
    logic        tach_valid;
    logic [1:0]  stall;

    typedef struct { int idx; int ch; int val; } pwm_exp_t;
    typedef struct { int idx; int c0; int c1; int stall; } tach_exp_t;

    pwm_exp_t  pwm_q[$];
    tach_exp_t tach_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = -2;
    int        hi[2];
    bit        tach1_on = 1'b0;

    fan_ctrl_multi #(
        .NumFans(2), .SettingWidth(4), .PwmWidth(8), .PrescaleDiv(1), .RampStep(16),
        .TachWindow(TW), .TachCntWidth(16), .StallMinPulses(2), .FailsafeEn(1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .setting_i    (setting),
        .tach_i       (tach),
        .fan_pwm_o    (fan_pwm),
        .tach_count_o (tach_count),
        .tach_valid_o (tach_valid),
        .stall_o      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Hand-derived per-period duty (high cycles per 256-cycle period) for the run plan
    function automatic int exp0(input int p);
        if (p <= 8)  return 16 * p;
        if (p <= 11) return 128;
        if (p <= 18) return 128 + 16 * (p - 11);
        if (p <= 21) return 256;
        if (p <= 36) return 256 - 16 * (p - 21);
        if (p <= 39) return 0;
        if (p <= 47) return 16 * (p - 39);
        if (p == 48) return 64;
        if (p <= 50) return 0;
        if (p <= 58) return 16 * (p - 50);
        if (p <= 88) return 128;
        return 128 + 16 * (p - 88);
    endfunction

    function automatic int exp1(input int p);
        if (p <= 50) return 0;
        if (p <= 54) return 16 * (p - 50);
        if (p <= 65) return 64 + 16 * (p - 54);
        if (p <= 74) return 256;
        if (p <= 85) return 256 - 16 * (p - 74);
        return 64;
    endfunction

    task automatic exp_pwm(input int p, input int ch, input int v);
        pwm_exp_t e;
        e.idx = p; e.ch = ch; e.val = v;
        pwm_q.push_back(e);
    endtask

    task automatic exp_tach(input int w, input int c0, input int c1, input int st);
        tach_exp_t e;
        e.idx = w; e.c0 = c0; e.c1 = c1; e.stall = st;
        tach_q.push_back(e);
    endtask

    // Tach sources: ch0 ten rising edges per window, ch1 five when enabled
    initial begin
        tach = 2'b00;
        forever begin
            @(negedge clk);
            tach[0] = (cyc % 100) >= 50;
            tach[1] = tach1_on && ((cyc % 200) >= 100);
        end
    end

    // Monitor: cyc counts clock edges since the block's internal reset released
    initial begin
        int p;
        int w;
        int i;
        hi = '{0, 0};
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cyc = -2;
                hi  = '{0, 0};
            end else begin
                cyc++;
                if (cyc > 0) begin
                    for (int ch = 0; ch < 2; ch++) if (fan_pwm[ch]) hi[ch]++;
                    if (cyc % 256 == 0) begin
                        p = cyc / 256 - 1;
                        i = 0;
                        while (i < pwm_q.size()) begin
                            if (pwm_q[i].idx == p) begin
                                check($sformatf("pwm_high ch%0d period %0d", pwm_q[i].ch, p),
                                      hi[pwm_q[i].ch], pwm_q[i].val);
                                pwm_q.delete(i);
                            end else begin
                                i++;
                            end
                        end
                        hi = '{0, 0};
                    end
                    if (tach_valid || (cyc % TW == 0)) begin
                        check("tach_valid timing", int'(tach_valid), int'(cyc % TW == 0));
                        if (tach_valid) begin
                            w = cyc / TW;
                            i = 0;
                            while (i < tach_q.size()) begin
                                if (tach_q[i].idx == w) begin
                                    check($sformatf("tach_count0 win %0d", w), int'(tach_count[15:0]), tach_q[i].c0);
                                    check($sformatf("tach_count1 win %0d", w), int'(tach_count[31:16]), tach_q[i].c1);
                                    check($sformatf("stall win %0d", w), int'(stall), tach_q[i].stall);
                                    tach_q.delete(i);
                                end else begin
                                    i++;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test (cyc %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        en      = 1'b1;
        setting = 8'h08;
        for (int p = 0; p <= 90; p++) begin
            exp_pwm(p, 0, exp0(p));
            exp_pwm(p, 1, exp1(p));
        end
        for (int w = 1; w <= 23; w++) begin
            exp_tach(w, 10, (w >= 19) ? 5 : 0, (w >= 14 && w <= 18) ? 2 : 0);
        end
        repeat (2) @(negedge clk);
        check("reset fan_pwm", int'(fan_pwm), 0);
        check("reset tach_count", int'(tach_count), 0);
        check("reset tach_valid", int'(tach_valid), 0);
        check("reset stall", int'(stall), 0);
        rst = 1'b0;

        wait_cyc(2826);  setting[3:0] = 4'd15;
        wait_cyc(5386);  setting[3:0] = 4'd0;
        wait_cyc(9994);  setting[3:0] = 4'd8;
        wait_cyc(12352); en = 1'b0;
        wait_cyc(12810); en = 1'b1; setting[7:4] = 4'd4;
        wait_cyc(18000); tach1_on = 1'b1;
        wait_cyc(22538); setting[3:0] = 4'd15;

        wait_cyc(23400);
        check("pre-reset fan_pwm", int'(fan_pwm), 1);
        check("pre-reset tach_count", int'(tach_count), 32'h0005_000A);
        rst = 1'b1;
        #1;
        check("async reset fan_pwm", int'(fan_pwm), 0);
        check("async reset tach_count", int'(tach_count), 0);
        check("async reset tach_valid", int'(tach_valid), 0);
        check("async reset stall", int'(stall), 0);
        repeat (3) @(negedge clk);
        for (int p = 0; p <= 3; p++) begin
            exp_pwm(p, 0, 16 * p);
            exp_pwm(p, 1, 16 * p);
        end
        exp_tach(1, 10, 5, 0);
        rst = 1'b0;

        wait_cyc(1100);
        check("pwm expectations left", pwm_q.size(), 0);
        check("tach expectations left", tach_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fan_ctrl_multi.md
Name: fan_ctrl_multi

Overview:
Multi-channel PWM fan controller for FPGA targets. It drives NumFans fan PWM outputs from per-channel speed settings, with a soft-start duty ramp on each channel. It also measures each fan's tachometer pulse rate over a fixed window and flags stalled fans. A stalled fan can optionally be forced to full speed.

Parameters:
NumFans, 2, number of independent fan channels
SettingWidth, 4, width of each speed setting
PwmWidth, 8, PWM period counter width; must be >= SettingWidth; period = 2^PwmWidth ticks
PrescaleDiv, 16, clk cycles per PWM tick; must be >= 1
RampStep, 16, maximum duty change per PWM period, in ticks; must be >= 1
TachWindow, 1000000, clk cycles per tachometer measurement window
TachCntWidth, 16, width of each tach pulse count
StallMinPulses, 2, minimum pulses per window for a spinning fan
FailsafeEn, 1, when 1 a stalled channel's target duty is forced to full

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  global enable
setting_i  in  NumFans*SettingWidth  per-channel speed setting; channel k at bits [k*SettingWidth +: SettingWidth]
tach_i  in  NumFans  asynchronous tachometer inputs
fan_pwm_o  out  NumFans  registered PWM outputs
tach_count_o  out  NumFans*TachCntWidth  pulse count latched at the end of the last window
tach_valid_o  out  1  one-cycle pulse when tach_count_o updates
stall_o  out  NumFans  sticky per-channel stall flag

Behaviour:
- Reset (async assert, sync deassert inside block): all counters, duty registers, fan_pwm_o, tach_count_o, tach_valid_o and stall_o are 0.
- Prescaler:
  - Counts 0..PrescaleDiv-1 and wraps.
  - tick = 1 in the cycle the count equals PrescaleDiv-1.
- PWM counter:
  - PwmWidth bits, increments on tick, wraps from 2^PwmWidth-1 to 0.
  - Period start = a tick on which the counter wraps to 0.
- Target duty (PwmWidth+1 bits), per channel:
  - setting = 0 → 0.
  - setting = 2^SettingWidth-1 → 2^PwmWidth (full).
  - Otherwise setting << (PwmWidth-SettingWidth).
  - If FailsafeEn and stall_o[k], target = full.
- Duty register (PwmWidth+1 bits), per channel, updated only at period start:
  - Moves toward target by at most RampStep and never overshoots.
  - Going up: duty = min(duty+RampStep, target). Going down: duty = max(duty-RampStep, target).
  - setting_i changes mid-period take effect at the next period start only.
- PWM output:
  - fan_pwm_o[k] is registered: 1 when PWM counter < duty[k].
  - duty = full gives constant 1; duty = 0 gives constant 0.
  - Output lags the counter by one cycle.
- en_i:
  - When 0, all duty registers are cleared to 0 at once and fan_pwm_o goes to 0 on the next cycle.
  - Prescaler and PWM counter keep running.
  - On re-enable, duty ramps up from 0.
- Tach input path:
  - Each tach_i passes through a 2-flop synchroniser.
  - A rising edge is detected on the synchronised signal.
- Tach measurement:
  - A window counter runs 0..TachWindow-1 continuously, independent of en_i.
  - Per-channel pulse counters increment on each detected edge and saturate at 2^TachCntWidth-1.
  - In the last window cycle: counts are latched to tach_count_o, tach_valid_o = 1 for one cycle, and pulse counters restart at 0. An edge in that same cycle is counted into the new window.
- Stall flag, evaluated at window end per channel:
  - Set if duty != 0 and latched count < StallMinPulses.
  - Cleared if count >= StallMinPulses or duty = 0.
  - Otherwise holds its value.

Test Plan:
- Ramp-up, PrescaleDiv=1, en_i=1: setting 8 from reset → duty goes 16, 32, ... 128 over 8 periods of 256 cycles; then fan_pwm_o is high for 128 of every 256 cycles.
- Full and off: setting 15 → after ramp, fan_pwm_o constantly 1 with no glitches at counter wrap. Then setting 0 → duty ramps 256→0 in steps of 16 (16 periods), then constantly 0.
- Disable: en_i=0 mid-period with duty 128 → fan_pwm_o = 0 next cycle. Re-enable → first period high for 16 cycles.
- Tach count, TachWindow=1000: drive 10 rising edges on tach_i[0] and 0 on tach_i[1] → tach_valid_o pulses once per 1000 cycles; tach_count_o = {0, 10}; stall_o[1] = 1 with setting[1] = 4; stall_o[0] = 0.
- Failsafe: channel 1 stalled with setting 4, FailsafeEn=1 → duty ramps to 256 and fan_pwm_o[1] is constantly high. Then drive 5 pulses per window → stall_o[1] clears at the next window end and duty ramps back down to 64.
- Async reset asserted mid-ramp and mid-window → all outputs 0 in the same cycle; after release, the first tach_valid_o comes TachWindow cycles later.
